// File: rtl/mem_line_adapter_pkg.sv
// Shared types and size helpers for the line-to-word memory adapter.
// The FSM encoding is fixed at 2 bits so that checkers can bind to the exported state.
package mem_line_adapter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    function automatic int beats_of(input int line_width, input int data_width);
        return line_width / data_width;
    endfunction

    function automatic int idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int word_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Read tag delay line: carries (valid, beat index) alongside each read command so the
// returning word lands in the right line slot after the memory's fixed read latency.
module mem_rd_tag_pipe
    import mem_line_adapter_pkg::*;
#(
    parameter int DEPTH     = 1,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IDX_WIDTH-1:0] in_idx,
    output logic                 out_valid,
    output logic [IDX_WIDTH-1:0] out_idx
);

    logic [DEPTH-1:0]                vld;
    logic [DEPTH-1:0][IDX_WIDTH-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            idx <= '0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/mem_line_adapter.sv
// Converts one cache-line request into BEATS back-to-back word commands and assembles
// the read words into a line. One transaction in flight; every output is a register.
module mem_line_adapter
    import mem_line_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [LINE_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [LINE_WIDTH-1:0] resp_rdata_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic                  cmd_valid_o,
    output logic                  wr_enable_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [1:0]            fsm_state
);

    localparam int BEATS      = beats_of(LINE_WIDTH, DATA_WIDTH);
    localparam int IW         = idx_width(BEATS);
    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [IW-1:0]         LAST_BEAT  = IW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(word_bytes(DATA_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

    typedef logic [BEATS-1:0][DATA_WIDTH-1:0] line_t;

    state_t                state, state_d;
    logic [IW-1:0]         beat, beat_d;
    logic                  wr_flag, wr_flag_d;
    line_t                 wline, wline_d;
    line_t                 cap, cap_d;
    logic                  req_ready_d, resp_valid_d, cmd_valid_d, wr_enable_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [LINE_WIDTH-1:0] resp_rdata_d;
    logic                  tag_valid;
    logic [IW-1:0]         tag_idx;

    // beat always names the command currently on the port, so it doubles as the read tag.
    mem_rd_tag_pipe #(
        .DEPTH     (RD_LATENCY),
        .IDX_WIDTH (IW)
    ) u_tag_pipe (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .in_valid  (cmd_valid_o & ~wr_enable_o),
        .in_idx    (beat),
        .out_valid (tag_valid),
        .out_idx   (tag_idx)
    );

    assign fsm_state = state;

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= S_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d      = state;
        beat_d       = beat;
        wr_flag_d    = wr_flag;
        wline_d      = wline;
        cap_d        = cap;
        req_ready_d  = 1'b0;
        resp_valid_d = resp_valid_o;
        resp_rdata_d = resp_rdata_o;
        cmd_valid_d  = 1'b0;
        wr_enable_d  = 1'b0;
        cmd_addr_d   = cmd_addr_o;
        wr_data_d    = wr_data_o;

        if (tag_valid) cap_d[tag_idx] = rd_data_i;

        case (state)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid_i && req_ready_o) begin
                    state_d     = S_ISSUE;
                    req_ready_d = 1'b0;
                    beat_d      = '0;
                    wr_flag_d   = req_write_i;
                    wline_d     = req_wdata_i;
                    cap_d       = '0;
                    cmd_valid_d = 1'b1;
                    wr_enable_d = req_write_i;
                    cmd_addr_d  = req_addr_i & ALIGN_MASK;
                    wr_data_d   = req_wdata_i[DATA_WIDTH-1:0];
                end
            end
            S_ISSUE: begin
                if (beat == LAST_BEAT) begin
                    beat_d = '0;
                    if (wr_flag) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    beat_d      = beat + 1'b1;
                    cmd_valid_d = 1'b1;
                    wr_enable_d = wr_flag;
                    cmd_addr_d  = cmd_addr_o + WORD_STEP;
                    wr_data_d   = wline[beat_d];
                end
            end
            S_DRAIN: begin
                if (tag_valid && tag_idx == LAST_BEAT) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = cap_d;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            beat         <= '0;
            wr_flag      <= 1'b0;
            wline        <= '0;
            cap          <= '0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            cmd_valid_o  <= 1'b0;
            wr_enable_o  <= 1'b0;
            cmd_addr_o   <= '0;
            wr_data_o    <= '0;
        end else begin
            beat         <= beat_d;
            wr_flag      <= wr_flag_d;
            wline        <= wline_d;
            cap          <= cap_d;
            req_ready_o  <= req_ready_d;
            resp_valid_o <= resp_valid_d;
            resp_rdata_o <= resp_rdata_d;
            cmd_valid_o  <= cmd_valid_d;
            wr_enable_o  <= wr_enable_d;
            cmd_addr_o   <= cmd_addr_d;
            wr_data_o    <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_mem_line_adapter.sv
// Bench for mem_line_adapter: two instances (read latency 1 and 3), each with its own word
// memory, checked against a line-level reference memory kept in the bench.
module tb_mem_line_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid[2], req_ready[2], req_write[2];
    logic         resp_valid[2], resp_ready[2];
    logic         cmd_valid[2], wr_en[2];
    logic [31:0]  req_addr[2], cmd_addr[2], wr_data[2], rd_data[2];
    logic [127:0] req_wdata[2], resp_rdata[2];
    logic [1:0]   fsm_state[2];

    int n_tests = 0;
    int n_fail  = 0;

    mem_line_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WIDTH(128), .RD_LATENCY(1)) dut_l1 (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .req_write_i(req_write[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]), .resp_rdata_o(resp_rdata[0]),
        .cmd_addr_o(cmd_addr[0]), .cmd_valid_o(cmd_valid[0]), .wr_enable_o(wr_en[0]),
        .wr_data_o(wr_data[0]), .rd_data_i(rd_data[0]), .fsm_state(fsm_state[0])
    );

    mem_line_adapter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_WIDTH(128), .RD_LATENCY(3)) dut_l3 (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .req_write_i(req_write[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]), .resp_rdata_o(resp_rdata[1]),
        .cmd_addr_o(cmd_addr[1]), .cmd_valid_o(cmd_valid[1]), .wr_enable_o(wr_en[1]),
        .wr_data_o(wr_data[1]), .rd_data_i(rd_data[1]), .fsm_state(fsm_state[1])
    );

    // Word memory: row r holds bytes r*4+j after preset; reads return after a fixed latency.
    logic [31:0] mem[2][256];
    logic [31:0] rpipe[2][3];
    logic        mem_init = 1'b0;

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i * 4);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[u][i] <= pat(i);
            end else if (cmd_valid[u] && wr_en[u]) begin
                mem[u][cmd_addr[u][9:2]] <= wr_data[u];
            end
            rpipe[u][0] <= (cmd_valid[u] && !wr_en[u]) ? mem[u][cmd_addr[u][9:2]] : 32'h0;
            rpipe[u][1] <= rpipe[u][0];
            rpipe[u][2] <= rpipe[u][1];
        end
    end
    assign rd_data[0] = rpipe[0][0];
    assign rd_data[1] = rpipe[1][2];

    // Reference model: what each memory should contain, updated per whole-line write.
    logic [31:0] ref_mem[2][256];

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [127:0] ref_line(input int u, input logic [31:0] addr);
        int b;
        b = int'(addr[9:4]) * 4;
        return {ref_mem[u][b+3], ref_mem[u][b+2], ref_mem[u][b+1], ref_mem[u][b]};
    endfunction

    int          obs_cyc[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic        obs_we[$];
    int          resp_cyc;
    logic [127:0] resp_line;

    // Drives one line request (from a negedge with the adapter idle), records every command
    // and the first response cycle relative to acceptance, then completes the handshake.
    task automatic run_txn(input int u, input logic wr, input logic [31:0] addr,
                           input logic [127:0] wdata, input int delay);
        obs_cyc.delete(); obs_addr.delete(); obs_data.delete(); obs_we.delete();
        resp_cyc = -1;
        if (wr) begin
            for (int k = 0; k < 4; k++) ref_mem[u][int'(addr[9:4]) * 4 + k] = wdata[k*32 +: 32];
        end
        req_valid[u]  = 1'b1;
        req_write[u]  = wr;
        req_addr[u]   = addr;
        req_wdata[u]  = wdata;
        resp_ready[u] = (delay == 0);
        @(negedge clk);
        req_valid[u] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (cmd_valid[u]) begin
                obs_cyc.push_back(c);
                obs_addr.push_back(cmd_addr[u]);
                obs_data.push_back(wr_data[u]);
                obs_we.push_back(wr_en[u]);
            end
            if (resp_valid[u]) begin
                resp_cyc  = c;
                resp_line = resp_rdata[u];
                break;
            end
            @(negedge clk);
        end
        repeat (delay) @(negedge clk);
        resp_ready[u] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({req_ready[u], resp_valid[u], cmd_valid[u], wr_en[u]} !== 4'b1000 ||
                cmd_addr[u] !== 32'h0 || wr_data[u] !== 32'h0 || resp_rdata[u] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_state u=%0d: rdy=%b rv=%b cv=%b we=%b addr=%h wd=%h rd=%h, want 1 0 0 0 and zeros",
                         u, req_ready[u], resp_valid[u], cmd_valid[u], wr_en[u], cmd_addr[u], wr_data[u], resp_rdata[u]);
            end
        end
    endtask

    task automatic test_read_basic(input int u);
        logic [127:0] exp_line;
        int bad;
        exp_line = ref_line(u, 32'h4000_0000);
        run_txn(u, 1'b0, 32'h4000_0000, 128'h0, 0);
        n_tests++;
        if (resp_cyc != 5 + lat_of(u)) begin
            n_fail++;
            $display("FAIL read_latency u=%0d: got %0d want %0d", u, resp_cyc, 5 + lat_of(u));
        end
        n_tests++;
        if (resp_line !== exp_line) begin
            n_fail++;
            $display("FAIL read_data u=%0d: got %h want %h", u, resp_line, exp_line);
        end
        bad = 0;
        if (obs_addr.size() != 4) bad = 99;
        else for (int k = 0; k < 4; k++)
            if (obs_addr[k] !== 32'h4000_0000 + 32'(4 * k) || obs_we[k] !== 1'b0 || obs_cyc[k] != k + 1) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL read_cmds u=%0d: %0d commands, %0d bad, want 4 commands 0 bad", u, obs_addr.size(), bad);
        end
    endtask

    task automatic test_write_readback;
        logic [127:0] wline;
        int bad;
        wline = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        run_txn(0, 1'b1, 32'h4000_0010, wline, 0);
        n_tests++;
        if (resp_cyc != 5) begin
            n_fail++;
            $display("FAIL write_latency: got %0d want 5", resp_cyc);
        end
        bad = 0;
        if (obs_addr.size() != 4) bad = 99;
        else for (int k = 0; k < 4; k++)
            if (obs_addr[k] !== 32'h4000_0010 + 32'(4 * k) || obs_we[k] !== 1'b1 ||
                obs_data[k] !== wline[k*32 +: 32] || obs_cyc[k] != k + 1) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write_cmds: %0d commands, %0d bad (first data %h), want 4 commands 0 bad",
                     obs_addr.size(), bad, (obs_data.size() > 0) ? obs_data[0] : 32'h0);
        end
        run_txn(0, 1'b0, 32'h4000_0010, 128'h0, 0);
        n_tests++;
        if (resp_line !== wline) begin
            n_fail++;
            $display("FAIL write_readback: got %h want %h", resp_line, wline);
        end
    endtask

    task automatic test_unaligned;
        logic [127:0] exp_line;
        exp_line = ref_line(0, 32'h4000_0020);
        run_txn(0, 1'b0, 32'h4000_0024, 128'h0, 0);
        n_tests++;
        if (obs_addr.size() != 4 || obs_addr[0] !== 32'h4000_0020 || obs_addr[3] !== 32'h4000_002C) begin
            n_fail++;
            $display("FAIL unaligned_cmds: %0d commands, first %h, want 4 commands from 40000020",
                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 32'h0);
        end
        n_tests++;
        if (resp_line !== exp_line) begin
            n_fail++;
            $display("FAIL unaligned_data: got %h want %h", resp_line, exp_line);
        end
    endtask

    task automatic test_resp_stall;
        logic [127:0] held;
        int seen, bad, cmds;
        seen = -1;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h4000_0050; resp_ready[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (resp_valid[0]) begin seen = c; break; end
            @(negedge clk);
        end
        n_tests++;
        if (seen != 6) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d want 6", seen);
        end
        held = resp_rdata[0];
        n_tests++;
        if (held !== ref_line(0, 32'h4000_0050)) begin
            n_fail++;
            $display("FAIL stall_data: got %h want %h", held, ref_line(0, 32'h4000_0050));
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h4000_0060;
                req_wdata[0] = {$urandom, $urandom, $urandom, $urandom};
            end
            if (c == 2) req_valid[0] = 1'b0;
            if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== held || req_ready[0] !== 1'b0 || cmd_valid[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        n_tests++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: resp_valid=%b req_ready=%b want 0 1", resp_valid[0], req_ready[0]);
        end
        cmds = 0;
        repeat (4) begin
            if (cmd_valid[0]) cmds++;
            @(negedge clk);
        end
        n_tests++;
        if (cmds != 0) begin
            n_fail++;
            $display("FAIL stall_ignored_req: %0d commands issued, want 0", cmds);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] exp_line;
        int found;
        found = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h4000_0070; resp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (cmd_valid[1] && cmd_addr[1] == 32'h4000_0078) begin found = 1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (found == 0) begin
            n_fail++;
            $display("FAIL reset_mid_beat2: beat 2 command not seen, want it within 10 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cmd_valid[1] !== 1'b0 || resp_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: cmd_valid=%b resp_valid=%b want 0 0", cmd_valid[1], resp_valid[1]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready[1] !== 1'b1 || cmd_valid[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: req_ready=%b cmd_valid=%b want 1 0", req_ready[1], cmd_valid[1]);
        end
        exp_line = ref_line(1, 32'h4000_0030);
        run_txn(1, 1'b0, 32'h4000_0030, 128'h0, 0);
        n_tests++;
        if (resp_line !== exp_line || resp_cyc != 8) begin
            n_fail++;
            $display("FAIL reset_mid_fresh_read: got %h at %0d want %h at 8", resp_line, resp_cyc, exp_line);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 16; it++) begin
            int u, delay, bad, want_cyc;
            logic wr;
            logic [31:0] addr, base;
            logic [127:0] wline, exp_line;
            u     = $urandom_range(0, 1);
            wr    = 1'($urandom_range(0, 1));
            addr  = 32'h4000_0000 + 32'($urandom_range(0, 1023));
            base  = addr & ~32'hF;
            wline = {$urandom, $urandom, $urandom, $urandom};
            delay = $urandom_range(0, 3);
            exp_line = ref_line(u, addr);
            want_cyc = wr ? 5 : 5 + lat_of(u);
            n_tests++;
            if (req_ready[u] !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_ready it=%0d u=%0d: req_ready=%b want 1", it, u, req_ready[u]);
            end
            run_txn(u, wr, addr, wline, delay);
            bad = 0;
            if (obs_addr.size() != 4) bad = 99;
            else for (int k = 0; k < 4; k++)
                if (obs_addr[k] !== base + 32'(4 * k) || obs_we[k] !== wr || obs_cyc[k] != k + 1 ||
                    (wr && obs_data[k] !== wline[k*32 +: 32])) bad++;
            n_tests++;
            if (bad != 0 || resp_cyc != want_cyc) begin
                n_fail++;
                $display("FAIL rand_cmds it=%0d u=%0d wr=%b: %0d bad beats, resp at %0d, want 0 bad, resp at %0d",
                         it, u, wr, bad, resp_cyc, want_cyc);
            end
            if (!wr) begin
                n_tests++;
                if (resp_line !== exp_line) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d u=%0d addr=%h: got %h want %h", it, u, addr, resp_line, exp_line);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 32'h0;
            req_wdata[u] = 128'h0; resp_ready[u] = 1'b1;
            for (int i = 0; i < 256; i++) ref_mem[u][i] = pat(i);
        end
        mem_init = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_read_basic(0);
        test_read_basic(1);
        test_write_readback();
        test_unaligned();
        test_resp_stall();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
